// File: rtl/nf10_router_pkg.sv
// Shared definitions for the router input arbiter: FSM encoding, queue bound
// and a width helper.
package nf10_router_pkg;

  localparam int MAX_QUEUES = 8;

  typedef enum logic {
    ARB = 1'b0,
    PKT = 1'b1
  } arb_state_e;

  // ceil(log2(n)), never below 1 so a 2-queue grant still has a bit
  function automatic int log2(input int n);
    log2 = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) log2 = i + 1;
  endfunction

endpackage

// File: rtl/nf10_router_input_arbiter_if.sv
// AXI4-Stream bundle; N lanes of TDATA/TUSER packed side by side, lane i in slice i.
interface nf10_router_input_arbiter_if #(
  parameter int N  = 1,
  parameter int DW = 256,
  parameter int UW = 128
) ();
  logic [N*DW-1:0]   TDATA;
  logic [N*DW/8-1:0] TSTRB;
  logic [N*UW-1:0]   TUSER;
  logic [N-1:0]      TVALID;
  logic [N-1:0]      TLAST;
  logic [N-1:0]      TREADY;

  modport master (output TDATA, TSTRB, TUSER, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TSTRB, TUSER, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/nf10_router_input_arbiter_rr.sv
// Combinational round-robin pick: first request searching upward from last_i+1, wrapping.
module rr_priority_arbiter #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    int idx;
    grant_o = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_i) + k) % N;
      if (req_i[idx]) begin
        grant_o = IW'(idx);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nf10_router_input_arbiter.sv
// Packet-granular round-robin merge of NUM_QUEUES AXI4-Stream queues onto one
// stream; one ARB bubble per packet, no buffering, per-queue packet counters.
module nf10_router_input_arbiter
  import nf10_router_pkg::*;
#(
  parameter int NUM_QUEUES           = 5,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  nf10_router_input_arbiter_if.slave        S_AXIS,
  nf10_router_input_arbiter_if.master       M_AXIS,
  input  logic [NUM_QUEUES-1:0]             QUEUE_ENABLE,
  input  logic                              CNT_CLEAR,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]   PKT_CNT,
  output logic [log2(NUM_QUEUES)-1:0]       GRANT
);

  localparam int GW  = log2(NUM_QUEUES);
  localparam int SSW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int MSW = C_M_AXIS_DATA_WIDTH / 8;

  arb_state_e                           state_q, state_d;
  logic [GW-1:0]                        grant_q, grant_d;
  logic [GW-1:0]                        last_q, last_d;
  logic [GW-1:0]                        pick;
  logic                                 any_req;
  logic [NUM_QUEUES-1:0]                eligible;
  logic                                 pkt_done;
  logic [NUM_QUEUES-1:0][CNT_WIDTH-1:0] cnt_q;

  assign eligible = S_AXIS.TVALID & QUEUE_ENABLE;

  rr_priority_arbiter #(.N(NUM_QUEUES), .IW(GW)) u_rr (
    .req_i   (eligible),
    .last_i  (last_q),
    .grant_o (pick),
    .any_o   (any_req)
  );

  // Stream mux: data lanes always follow the grant, handshakes only in PKT.
  always_comb begin
    M_AXIS.TDATA  = S_AXIS.TDATA[int'(grant_q)*C_S_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH];
    M_AXIS.TSTRB  = S_AXIS.TSTRB[int'(grant_q)*SSW +: MSW];
    M_AXIS.TUSER  = S_AXIS.TUSER[int'(grant_q)*C_S_AXIS_TUSER_WIDTH +: C_M_AXIS_TUSER_WIDTH];
    M_AXIS.TLAST  = S_AXIS.TLAST[grant_q];
    M_AXIS.TVALID = 1'b0;
    S_AXIS.TREADY = '0;
    if (state_q == PKT) begin
      M_AXIS.TVALID          = S_AXIS.TVALID[grant_q];
      S_AXIS.TREADY[grant_q] = M_AXIS.TREADY[0];
    end
  end

  assign pkt_done = (state_q == PKT) & M_AXIS.TVALID[0] & M_AXIS.TREADY[0] & M_AXIS.TLAST[0];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB: if (any_req) begin
        state_d = PKT;
        grant_d = pick;
        last_d  = pick;
      end
      PKT: if (pkt_done) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // last_q starts at the top queue so queue 0 is first in line after reset
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state_q <= ARB;
      grant_q <= '0;
      last_q  <= GW'(NUM_QUEUES - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Clear beats a same-cycle increment; counters wrap naturally.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET || CNT_CLEAR) cnt_q <= '0;
    else if (pkt_done)          cnt_q[grant_q] <= cnt_q[grant_q] + CNT_WIDTH'(1);
  end

  assign PKT_CNT = cnt_q;
  assign GRANT   = grant_q;

endmodule
